// File: rtl/tx_qam_pipe.sv
// rtl/tx_qam_pipe.sv - PN source, K=3 rate-1/2 encoder and BPSK/QPSK/16QAM mapper
//
// Ports:
//   sys_clk                    clock, all state on rising edge
//   reset                      synchronous, active-high
//   start / stop               begin run (IDLE only) / end run (RUN only)
//   mode[1:0]                  00 BPSK, 01 QPSK, 10 16QAM, 11 QPSK; latched at start
//   has_error                  negate I on every ERR_PERIOD-th formed symbol
//   out_ready                  downstream accepts the current symbol
//   out_valid                  channel_outI/Q hold a symbol
//   channel_outI/channel_outQ  signed OUT_W symbol levels
//   busy                       high whenever not IDLE

module tx_qam_pipe #(
  parameter int                  LFSR_LEN   = 7,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS  = 7'b1100000,
  parameter logic [LFSR_LEN-1:0] SEED       = '1,
  parameter int                  OUT_W      = 4,
  parameter int                  ERR_PERIOD = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic                    has_error,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] channel_outI,
  output logic signed [OUT_W-1:0] channel_outQ,
  output logic                    busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // An all-zero seed would lock the PN register, so it is replaced by 1.
  localparam logic [LFSR_LEN-1:0] SEED_LOAD = (SEED == '0) ? LFSR_LEN'(1) : SEED;

  localparam int               CNT_W    = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
  localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(ERR_PERIOD - 1);

  localparam logic signed [OUT_W-1:0] LV_P1 = OUT_W'(1);
  localparam logic signed [OUT_W-1:0] LV_M1 = OUT_W'(-1);
  localparam logic signed [OUT_W-1:0] LV_P3 = OUT_W'(3);
  localparam logic signed [OUT_W-1:0] LV_M3 = OUT_W'(-3);

  logic [1:0]          state;
  logic [1:0]          mode_q;
  logic [LFSR_LEN-1:0] lfsr;
  logic                s0;
  logic                s1;
  logic [7:0]          bit_buf;   // bit 0 is the oldest bit; bits at or above count are always 0
  logic [3:0]          count;
  logic                tail_cnt;
  logic [CNT_W-1:0]    sym_cnt;

  logic [3:0]              k;
  logic                    enc_en;
  logic                    m;
  logic                    fb;
  logic                    c0;
  logic                    c1;
  logic                    form;
  logic [3:0]              take;
  logic [3:0]              count_pop;
  logic [7:0]              buf_pop;
  logic [9:0]              push_vec;
  logic [7:0]              buf_next;
  logic [3:0]              count_next;
  logic signed [OUT_W-1:0] sym_raw;
  logic signed [OUT_W-1:0] sym_i;
  logic signed [OUT_W-1:0] sym_q;

  function automatic logic signed [OUT_W-1:0] gray_lvl(input logic first, input logic second);
    case ({first, second})
      2'b00:   return LV_M3;
      2'b01:   return LV_M1;
      2'b11:   return LV_P1;
      default: return LV_P3;
    endcase
  endfunction

  always_comb begin
    case (mode_q)
      2'b00:   k = 4'd1;
      2'b10:   k = 4'd4;
      default: k = 4'd2;
    endcase
  end

  always_comb begin
    enc_en = ((state == ST_RUN) || (state == ST_TAIL)) && (count <= 4'd6);
    m      = (state == ST_TAIL) ? 1'b0 : lfsr[LFSR_LEN-1];
    fb     = ^(lfsr & LFSR_TAPS);
    c0     = m ^ s0 ^ s1;
    c1     = m ^ s1;
    // In DRAIN a short remainder is emitted; the zero bits above count act as padding.
    form   = (state != ST_IDLE) && (!out_valid || out_ready) &&
             ((count >= k) || ((state == ST_DRAIN) && (count != 4'd0)));
    take   = form ? ((count >= k) ? k : count) : 4'd0;
    // Pop first, then append the new pair behind whatever remains.
    count_pop  = count - take;
    buf_pop    = bit_buf >> take;
    push_vec   = {8'd0, c1, c0} << count_pop;
    buf_next   = enc_en ? (buf_pop | push_vec[7:0]) : buf_pop;
    count_next = count_pop + (enc_en ? 4'd2 : 4'd0);
  end

  always_comb begin
    sym_raw = LV_M1;
    sym_q   = '0;
    case (mode_q)
      2'b00: begin
        sym_raw = bit_buf[0] ? LV_P1 : LV_M1;
        sym_q   = '0;
      end
      2'b10: begin
        sym_raw = gray_lvl(bit_buf[0], bit_buf[1]);
        sym_q   = gray_lvl(bit_buf[2], bit_buf[3]);
      end
      default: begin
        sym_raw = bit_buf[0] ? LV_P1 : LV_M1;
        sym_q   = bit_buf[1] ? LV_P1 : LV_M1;
      end
    endcase
    sym_i = (has_error && (sym_cnt == ERR_LAST)) ? -sym_raw : sym_raw;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_q       <= 2'b01;
      lfsr         <= SEED_LOAD;
      s0           <= 1'b0;
      s1           <= 1'b0;
      bit_buf      <= '0;
      count        <= '0;
      tail_cnt     <= 1'b0;
      sym_cnt      <= '0;
      out_valid    <= 1'b0;
      channel_outI <= '0;
      channel_outQ <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            mode_q   <= mode;
            lfsr     <= SEED_LOAD;
            s0       <= 1'b0;
            s1       <= 1'b0;
            bit_buf  <= '0;
            count    <= '0;
            tail_cnt <= 1'b0;
            sym_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (stop) state <= ST_TAIL;
        end
        ST_TAIL: begin
          // Leave after the second flushing step actually executes.
          if (enc_en && tail_cnt) state <= ST_DRAIN;
        end
        default: begin
          if ((count == 4'd0) && (!out_valid || out_ready)) state <= ST_IDLE;
        end
      endcase

      if (state != ST_IDLE) begin
        bit_buf <= buf_next;
        count   <= count_next;
        if (enc_en) begin
          s1 <= s0;
          s0 <= m;
          if (state == ST_RUN)  lfsr     <= {lfsr[LFSR_LEN-2:0], fb};
          if (state == ST_TAIL) tail_cnt <= 1'b1;
        end
      end

      if (form) begin
        out_valid    <= 1'b1;
        channel_outI <= sym_i;
        channel_outQ <= sym_q;
        sym_cnt      <= (sym_cnt == ERR_LAST) ? '0 : sym_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/tx_qam_pipe.md
TX_QAM_PIPE -- requirements
Module: tx_qam_pipe

Interface
REQ-001 Parameter LFSR_LEN, default 7: PN generator register length (3..16).
REQ-002 Parameter LFSR_TAPS, default 7'b1100000: feedback tap mask, bit i set = lfsr[i] in XOR.
REQ-003 Parameter SEED, default all-ones: PN load value; SEED=0 SHALL load 1 instead.
REQ-004 Parameter OUT_W, default 4: signed I/Q output width (>=3).
REQ-005 Parameter ERR_PERIOD, default 16: error-injection symbol period (>=1).
REQ-006 sys_clk  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  begin run; sampled only in IDLE.
REQ-009 stop  in  1  end run; sampled only in RUN.
REQ-010 mode  in  2  00 BPSK, 01 QPSK, 10 16QAM, 11 treated as QPSK; captured at start.
REQ-011 has_error  in  1  enable periodic error injection.
REQ-012 out_ready  in  1  downstream accepts symbol.
REQ-013 out_valid  out  1  symbol on channel_outI/Q valid.
REQ-014 channel_outI  out  OUT_W signed  in-phase symbol.
REQ-015 channel_outQ  out  OUT_W signed  quadrature symbol.
REQ-016 busy  out  1  high whenever state != IDLE.

Function
REQ-017 FSM states IDLE, RUN, TAIL, DRAIN; IDLE->RUN on start; RUN->TAIL on stop; TAIL->DRAIN after 2 tail encoder steps; DRAIN->IDLE when buffer empty and no symbol pending.
REQ-018 On IDLE->RUN: LFSR<=SEED, encoder state<=0, bit buffer count<=0, symbol counter<=0, mode latched; mode changes mid-run ignored.
REQ-019 PN step: m = lfsr[LFSR_LEN-1]; fb = XOR(lfsr & LFSR_TAPS); lfsr <= {lfsr[LFSR_LEN-2:0], fb}.
REQ-020 Encoder rate 1/2, K=3, state (s0 newest, s1 oldest): c0 = m^s0^s1, c1 = m^s1; then s1<=s0, s0<=m; c0 enters buffer before c1.
REQ-021 Bit buffer 8 bits FIFO order; one encoder step per cycle in RUN/TAIL iff current count <= 6; never overflows.
REQ-022 TAIL: encoder input m forced 0 for exactly 2 steps (LFSR frozen); steps stall when count > 6.
REQ-023 k = 1/2/4 bits per symbol for BPSK/QPSK/16QAM; symbol formed when count >= k and (!out_valid || out_ready); encode and form in same cycle allowed, count += 2*enc - k*form.
REQ-024 DRAIN with 0 < count < k: remaining bits zero-padded to k and emitted as final symbol.
REQ-025 BPSK: b0 1->I=+1, 0->I=-1; Q=0.
REQ-026 QPSK: b0 ->I, b1 ->Q, 1->+1, 0->-1.
REQ-027 16QAM: (b0,b1)->I, (b2,b3)->Q, Gray 00->-3, 01->-1, 11->+1, 10->+3.
REQ-028 out_valid held with I/Q stable until out_ready; handshake = out_valid & out_ready.
REQ-029 Symbol counter increments per formed symbol, wraps at ERR_PERIOD; symbol formed with counter == ERR_PERIOD-1 and has_error=1 SHALL have I negated.
REQ-030 First out_valid rises 2 cycles after start-sampling edge for BPSK/QPSK, 3 cycles for 16QAM, given out_ready=1.
REQ-031 start in non-IDLE and stop outside RUN ignored; start and stop together in IDLE -> RUN only.

Reset
REQ-032 reset=1: state IDLE, out_valid=0, channel_outI=0, channel_outQ=0, busy=0, count=0, LFSR=SEED, counters 0; overrides any operation mid-run, pending symbol discarded.

Verification
REQ-033 Defaults, QPSK, start, out_ready=1 -> first symbols (I,Q) = (+1,+1) then (-1,+1); first out_valid 2 cycles after start.
REQ-034 BPSK, same seed -> first three I = +1,+1,-1, Q=0 throughout.
REQ-035 16QAM -> first symbol I=+1, Q=-1, out_valid 3 cycles after start.
REQ-036 QPSK, out_ready=0 for 10 cycles after first valid -> I/Q held (+1,+1), count saturates at 8, no bit lost: next symbols continue (-1,+1).
REQ-037 ERR_PERIOD=4, has_error=1, QPSK -> symbols 3, 7, 11 (0-based) I negated, others unchanged; has_error=0 -> no change.
REQ-038 16QAM, stop mid-run, then reset asserted during DRAIN -> tail steps zero input, last symbol zero-padded; reset clears out_valid, busy next edge.
